mem_access_ctrl: RTL

Sequential memory-stage controller between execute and the shared RAM/writeback path. Accepts one instruction per handshake from execute. For LDR (opcode 4'b1001) and STR (4'b1010) it owns the RAM bus through a request/acknowledge FSM, stalls upstream until the access completes, and presents load data for writeback. All other opcodes pass the ALU result straight to writeback with one cycle of latency.

---
 rtl/mem_pkg.sv | 22 ++
 rtl/mem_timeout_ctr.sv | 42 ++++
 rtl/mem_access_ctrl.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the memory-stage controller: opcodes, RAM direction
// encodings, the controller state type and a small opcode decode helper.
package mem_pkg;

  localparam logic [3:0] OP_LDR = 4'b1001;
  localparam logic [3:0] OP_STR = 4'b1010;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  // True for the two opcodes that need the RAM bus
  function automatic logic is_mem_op(input logic [3:0] op);
    return (op == OP_LDR) || (op == OP_STR);
  endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// Access watchdog for the memory-stage controller. Counts cycles while 'run'
// is high and flags 'expired' during the TIMEOUT-th such cycle, so the
// controller can abandon the access at the end of that cycle. 'clear' holds
// the count at zero while no access is in flight.
module mem_timeout_ctr #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // count_q holds the number of ACCESS cycles already completed
  assign expired = run && (count_q == CNT_W'(TIMEOUT - 1));

  // Next count: zero outside an access, advance once per access cycle
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (run && !expired) begin
      count_d = count_q + 1'b1;
    end
  end

  // Count register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory-stage controller between execute and the shared RAM/writeback path.
// LDR/STR own the RAM bus through a request/acknowledge handshake and stall
// execute until the RAM acknowledges; every other opcode forwards its ALU
// result to writeback one cycle after it is accepted.
// Optional feature: define MEM_TIMEOUT_EN to abort accesses that see no
// ram_ack within TIMEOUT cycles (reported as a one-cycle mem_err pulse).
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
`ifdef MEM_TIMEOUT_EN
  , parameter int TIMEOUT = 15
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [3:0]        opcode,
  input  logic [DATA_W-1:0] source1,
  input  logic [DATA_W-1:0] source2,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] ram_rdata,
  input  logic              ram_ack,
  output logic              ram_en,
  output logic              ram_rw,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              address_sel,
  output logic              stall,
  output logic              wb_valid,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_from_mem,
  output logic              mem_err
);

  state_e state_q, state_d;

  logic              ram_en_q,      ram_en_d;
  logic              ram_rw_q,      ram_rw_d;
  logic [ADDR_W-1:0] ram_addr_q,    ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q,   ram_wdata_d;
  logic              address_sel_q, address_sel_d;
  logic              wb_valid_q,    wb_valid_d;
  logic [DATA_W-1:0] wb_data_q,     wb_data_d;
  logic              wb_from_mem_q, wb_from_mem_d;
  logic              mem_err_q,     mem_err_d;
  logic              is_load_q,     is_load_d;

  logic in_access;
  logic can_accept;
  logic accept_mem;
  logic accept_alu;
  logic timeout_hit;

  // Upper address operand bits never reach the RAM bus
  logic unused_src1_hi;
  assign unused_src1_hi = ^source1[DATA_W-1:ADDR_W];

  // A new instruction is only looked at when no access is in flight
  assign in_access  = (state_q == ACCESS);
  assign can_accept = !in_access;
  assign accept_mem = can_accept && in_valid && is_mem_op(opcode);
  assign accept_alu = can_accept && in_valid && !is_mem_op(opcode);

  assign stall = in_access || accept_mem;

`ifdef MEM_TIMEOUT_EN
  mem_timeout_ctr #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout_ctr (
    .clk    (clk),
    .rst    (rst),
    .clear  (!in_access),
    .run    (in_access),
    .expired(timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: IDLE and DONE accept alike; ACCESS leaves on ack or abort
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: state_d = accept_mem ? ACCESS : IDLE;
      ACCESS:     if (ram_ack || timeout_hit) state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  // Output next values: registered outputs hold unless an event updates them
  always_comb begin
    ram_en_d      = ram_en_q;
    ram_rw_d      = ram_rw_q;
    ram_addr_d    = ram_addr_q;
    ram_wdata_d   = ram_wdata_q;
    address_sel_d = address_sel_q;
    wb_valid_d    = 1'b0;
    wb_data_d     = wb_data_q;
    wb_from_mem_d = wb_from_mem_q;
    mem_err_d     = 1'b0;
    is_load_d     = is_load_q;

    if (accept_mem) begin
      ram_en_d      = 1'b1;
      address_sel_d = 1'b1;
      ram_addr_d    = source1[ADDR_W-1:0];
      is_load_d     = (opcode == OP_LDR);
      ram_rw_d      = (opcode == OP_LDR) ? RW_READ : RW_WRITE;
      if (opcode == OP_STR) begin
        ram_wdata_d = source2;
      end
    end else if (accept_alu) begin
      wb_valid_d    = 1'b1;
      wb_data_d     = alu_result;
      wb_from_mem_d = 1'b0;
    end else if (in_access) begin
      if (ram_ack) begin
        ram_en_d      = 1'b0;
        address_sel_d = 1'b0;
        if (is_load_q) begin
          wb_valid_d    = 1'b1;
          wb_data_d     = ram_rdata;
          wb_from_mem_d = 1'b1;
        end
      end else if (timeout_hit) begin
        ram_en_d      = 1'b0;
        address_sel_d = 1'b0;
        mem_err_d     = 1'b1;
      end
    end
  end

  // Output and access-kind registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      ram_en_q      <= 1'b0;
      ram_rw_q      <= RW_READ;
      ram_addr_q    <= '0;
      ram_wdata_q   <= '0;
      address_sel_q <= 1'b0;
      wb_valid_q    <= 1'b0;
      wb_data_q     <= '0;
      wb_from_mem_q <= 1'b0;
      mem_err_q     <= 1'b0;
      is_load_q     <= 1'b0;
    end else begin
      ram_en_q      <= ram_en_d;
      ram_rw_q      <= ram_rw_d;
      ram_addr_q    <= ram_addr_d;
      ram_wdata_q   <= ram_wdata_d;
      address_sel_q <= address_sel_d;
      wb_valid_q    <= wb_valid_d;
      wb_data_q     <= wb_data_d;
      wb_from_mem_q <= wb_from_mem_d;
      mem_err_q     <= mem_err_d;
      is_load_q     <= is_load_d;
    end
  end

  assign ram_en      = ram_en_q;
  assign ram_rw      = ram_rw_q;
  assign ram_addr    = ram_addr_q;
  assign ram_wdata   = ram_wdata_q;
  assign address_sel = address_sel_q;
  assign wb_valid    = wb_valid_q;
  assign wb_data     = wb_data_q;
  assign wb_from_mem = wb_from_mem_q;
  assign mem_err     = mem_err_q;

endmodule
